doodle_motion_ctrl: RTL and testbench
=====================================

Name: doodle_motion_ctrl

Overview:
- Vertical-motion and world-scroll controller for the doodle character; sits directly downstream of the platform collision stage.
- Produces doodle_y, speed_y, fly and state for that stage, and consumes its bump and movement results.
- On a landing, scrolls the world so the landed platform settles at screen line 464, accumulates score, then relaunches the jump.
- Drives scroll_en/scroll_dy to the block generator and score/game_over to the display logic.

Parameters:
- LAND_Y, 10'd425: doodle_y when standing on a platform at line 464 (464 - doodle height 39); also the start position.
- JUMP_SPEED, 5'd20: initial upward speed at launch, in pixels per frame.
- GRAVITY, 5'd1: speed change per frame.
- MAX_FALL, 5'd20: terminal falling speed.
- SCROLL_STEP, 10'd8: maximum world scroll per frame, in pixels.
- DEATH_Y, 10'd441: game over when the next doodle_y would exceed this (doodle bottom below line 480).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-low
- start  input  1  level; begins a game from IDLE or OVER
- frame_tick  input  1  one-cycle pulse per video frame; all motion advances only on this pulse
- bump  input  1  from the collision stage; valid in FALL only
- movement  input  10  from the collision stage; 464 - block_y of the platform hit
- doodle_y  output  10  doodle top edge, in screen pixels
- speed_y  output  5  current vertical speed magnitude
- fly  output  1  1 while rising (collision is disabled)
- state  output  3  IDLE=0, RISE=1, FALL=2, SCROLL=3, OVER=4
- scroll_en  output  1  one-cycle pulse: shift blocks down by scroll_dy
- scroll_dy  output  10  scroll amount for this pulse; 0 when scroll_en=0
- score  output  16  accumulated scroll distance
- game_over  output  1  high while in OVER

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, doodle_y=LAND_Y, speed_y=0, fly=0, scroll_en=0, scroll_dy=0, score=0, game_over=0.
- All outputs are registered.
- scroll_en is cleared every cycle unless the same edge sets it, so it is a single-cycle pulse.
- IDLE / OVER:
  - start=1 on any cycle -> next state RISE, doodle_y=LAND_Y, speed_y=JUMP_SPEED, fly=1, score=0, game_over=0.
  - start has priority over a simultaneous frame_tick; no motion is applied on that cycle.
  - In OVER, all outputs hold, including doodle_y.
- RISE, on frame_tick:
  - doodle_y <= doodle_y - speed_y, saturating at 0.
  - If speed_y <= GRAVITY: speed_y <= 0, fly <= 0, state -> FALL.
  - Otherwise: speed_y <= speed_y - GRAVITY.
  - bump is ignored in this state.
- FALL, on frame_tick, evaluated with pre-update values:
  - If bump=1: doodle_y <= LAND_Y - movement (saturate at 0), speed_y <= 0, remaining <= movement.
    - If movement == 0 -> state RISE, speed_y=JUMP_SPEED, fly=1.
    - Otherwise -> state SCROLL.
  - Else if doodle_y + speed_y > DEATH_Y (11-bit compare): state -> OVER, game_over <= 1, doodle_y unchanged.
  - Otherwise: doodle_y <= doodle_y + speed_y; speed_y <= min(speed_y + GRAVITY, MAX_FALL).
- SCROLL, on frame_tick:
  - step = min(remaining, SCROLL_STEP).
  - scroll_en <= 1, scroll_dy <= step.
  - doodle_y <= doodle_y + step.
  - remaining <= remaining - step.
  - score <= score + step, saturating at 16'hFFFF.
  - When remaining - step == 0 -> state RISE, speed_y=JUMP_SPEED, fly=1, on the same edge.
  - bump is ignored in this state.
- remaining is an internal 10-bit register, cleared on reset.
- start is ignored in RISE, FALL and SCROLL.
- Without frame_tick, every state holds.
- Reset mid-operation: immediately returns to IDLE with the reset values, including scroll_en=0.

Test Plan:
- Reset, start=1 for one cycle, then 20 frame_ticks.
  -> doodle_y runs 425, 405, 386, … and ends at 215.
  -> After tick 20: speed_y=0, fly=0, state=FALL.
- Continue FALL with bump=0.
  -> Per tick, speed_y goes 1, 2, 3 …; doodle_y gains 0, 1, 2 …
  -> speed_y clamps at 20.
  -> When doodle_y + speed_y > 441: state=OVER, game_over=1, doodle_y frozen.
- In FALL at doodle_y=300, assert bump=1 with movement=100 on a tick.
  -> doodle_y=325, state=SCROLL.
  -> Next 13 ticks produce scroll_en pulses: 12×(scroll_dy=8), then scroll_dy=4.
  -> Ends with doodle_y=425, score=100, state=RISE, speed_y=20, fly=1.
- bump=1 with movement=0 in FALL.
  -> Direct to RISE, doodle_y=425, speed_y=20, no scroll_en pulse.
- bump=1 held during RISE and SCROLL ticks.
  -> No effect on state, doodle_y or score.
- Drive rst=0 mid-SCROLL after 5 steps.
  -> Next edge: state=IDLE, score=0, scroll_en=0, doodle_y=425.
- From OVER, start and frame_tick asserted together.
  -> state=RISE, doodle_y=425 with no motion, game_over=0, score=0.

Source files
------------

// File: rtl/doodle_motion_ctrl.sv
// Vertical motion and world-scroll controller for the doodle character.
// Handles jump, gravity, landing scroll, score accumulation and game over.
module doodle_motion_ctrl #(
   parameter logic [9:0] LAND_Y      = 10'd425,
   parameter logic [4:0] JUMP_SPEED  = 5'd20,
   parameter logic [4:0] GRAVITY     = 5'd1,
   parameter logic [4:0] MAX_FALL    = 5'd20,
   parameter logic [9:0] SCROLL_STEP = 10'd8,
   parameter logic [9:0] DEATH_Y     = 10'd441
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        frame_tick,
   input  logic        bump,
   input  logic [9:0]  movement,
   output logic [9:0]  doodle_y,
   output logic [4:0]  speed_y,
   output logic        fly,
   output logic [2:0]  state,
   output logic        scroll_en,
   output logic [9:0]  scroll_dy,
   output logic [15:0] score,
   output logic        game_over
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RISE   = 3'd1;
   localparam logic [2:0] ST_FALL   = 3'd2;
   localparam logic [2:0] ST_SCROLL = 3'd3;
   localparam logic [2:0] ST_OVER   = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [9:0]  doodle_y_q, doodle_y_d;
   logic [4:0]  speed_y_q, speed_y_d;
   logic        fly_q, fly_d;
   logic        scroll_en_q, scroll_en_d;
   logic [9:0]  scroll_dy_q, scroll_dy_d;
   logic [15:0] score_q, score_d;
   logic        game_over_q, game_over_d;
   logic [9:0]  remaining_q, remaining_d;

   logic [10:0] fall_sum;
   logic [5:0]  fall_speed;
   logic [9:0]  step;
   logic [16:0] score_sum;

   // Widened sums so the death test and the clamps see the carry.
   assign fall_sum   = {1'b0, doodle_y_q} + {6'd0, speed_y_q};
   assign fall_speed = {1'b0, speed_y_q} + {1'b0, GRAVITY};
   assign step       = (remaining_q < SCROLL_STEP) ? remaining_q : SCROLL_STEP;
   assign score_sum  = {1'b0, score_q} + {7'd0, step};

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned and no latch is inferred.
      state_d     = state_q;
      doodle_y_d  = doodle_y_q;
      speed_y_d   = speed_y_q;
      fly_d       = fly_q;
      score_d     = score_q;
      game_over_d = game_over_q;
      remaining_d = remaining_q;
      scroll_en_d = 1'b0;
      scroll_dy_d = 10'd0;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               state_d     = ST_RISE;
               doodle_y_d  = LAND_Y;
               speed_y_d   = JUMP_SPEED;
               fly_d       = 1'b1;
               score_d     = 16'd0;
               game_over_d = 1'b0;
            end
         end

         ST_RISE: begin
            if (frame_tick) begin
               doodle_y_d = (doodle_y_q > {5'd0, speed_y_q}) ?
                            doodle_y_q - {5'd0, speed_y_q} : 10'd0;
               if (speed_y_q <= GRAVITY) begin
                  speed_y_d = 5'd0;
                  fly_d     = 1'b0;
                  state_d   = ST_FALL;
               end else begin
                  speed_y_d = speed_y_q - GRAVITY;
               end
            end
         end

         ST_FALL: begin
            if (frame_tick) begin
               if (bump) begin
                  doodle_y_d  = (LAND_Y > movement) ? LAND_Y - movement : 10'd0;
                  speed_y_d   = 5'd0;
                  remaining_d = movement;
                  if (movement == 10'd0) begin
                     state_d   = ST_RISE;
                     speed_y_d = JUMP_SPEED;
                     fly_d     = 1'b1;
                  end else begin
                     state_d = ST_SCROLL;
                  end
               end else if (fall_sum > {1'b0, DEATH_Y}) begin
                  state_d     = ST_OVER;
                  game_over_d = 1'b1;
               end else begin
                  doodle_y_d = fall_sum[9:0];
                  speed_y_d  = (fall_speed > {1'b0, MAX_FALL}) ? MAX_FALL : fall_speed[4:0];
               end
            end
         end

         ST_SCROLL: begin
            if (frame_tick) begin
               scroll_en_d = 1'b1;
               scroll_dy_d = step;
               doodle_y_d  = doodle_y_q + step;
               remaining_d = remaining_q - step;
               score_d     = score_sum[16] ? 16'hFFFF : score_sum[15:0];
               if (remaining_q == step) begin
                  state_d   = ST_RISE;
                  speed_y_d = JUMP_SPEED;
                  fly_d     = 1'b1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         doodle_y_q  <= LAND_Y;
         speed_y_q   <= 5'd0;
         fly_q       <= 1'b0;
         scroll_en_q <= 1'b0;
         scroll_dy_q <= 10'd0;
         score_q     <= 16'd0;
         game_over_q <= 1'b0;
         remaining_q <= 10'd0;
      end else begin
         state_q     <= state_d;
         doodle_y_q  <= doodle_y_d;
         speed_y_q   <= speed_y_d;
         fly_q       <= fly_d;
         scroll_en_q <= scroll_en_d;
         scroll_dy_q <= scroll_dy_d;
         score_q     <= score_d;
         game_over_q <= game_over_d;
         remaining_q <= remaining_d;
      end
   end

   assign state     = state_q;
   assign doodle_y  = doodle_y_q;
   assign speed_y   = speed_y_q;
   assign fly       = fly_q;
   assign scroll_en = scroll_en_q;
   assign scroll_dy = scroll_dy_q;
   assign score     = score_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_doodle_motion_ctrl.sv
// Self-checking bench for doodle_motion_ctrl: directed scenarios plus
// randomized traffic compared against an integer-level behavioural model.
module tb_doodle_motion_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        frame_tick = 1'b0;
   logic        bump = 1'b0;
   logic [9:0]  movement = 10'd0;
   logic [9:0]  doodle_y;
   logic [4:0]  speed_y;
   logic        fly;
   logic [2:0]  state;
   logic        scroll_en;
   logic [9:0]  scroll_dy;
   logic [15:0] score;
   logic        game_over;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state (plain integers, spec-level rules)
   int m_state, m_y, m_spd, m_fly, m_rem, m_score, m_go, m_sen, m_sdy;

   doodle_motion_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
      .bump(bump), .movement(movement), .doodle_y(doodle_y),
      .speed_y(speed_y), .fly(fly), .state(state), .scroll_en(scroll_en),
      .scroll_dy(scroll_dy), .score(score), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic model_reset();
      m_state = 0; m_y = 425; m_spd = 0; m_fly = 0; m_rem = 0;
      m_score = 0; m_go = 0; m_sen = 0; m_sdy = 0;
   endtask

   task automatic launch();
      m_state = 1; m_spd = 20; m_fly = 1;
   endtask

   task automatic model_step(input bit s, input bit ft, input bit b, input int mv, input bit rn);
      int st;
      m_sen = 0;
      m_sdy = 0;
      if (!rn) begin
         model_reset();
      end else if (m_state == 0 || m_state == 4) begin
         if (s) begin
            launch();
            m_y = 425; m_score = 0; m_go = 0;
         end
      end else if (ft) begin
         if (m_state == 1) begin
            m_y = imax(m_y - m_spd, 0);
            if (m_spd <= 1) begin
               m_spd = 0; m_fly = 0; m_state = 2;
            end else begin
               m_spd = m_spd - 1;
            end
         end else if (m_state == 2) begin
            if (b) begin
               m_y = imax(425 - mv, 0); m_spd = 0; m_rem = mv;
               if (mv == 0) launch();
               else m_state = 3;
            end else if (m_y + m_spd > 441) begin
               m_state = 4; m_go = 1;
            end else begin
               m_y = m_y + m_spd;
               m_spd = imin(m_spd + 1, 20);
            end
         end else begin
            st = imin(m_rem, 8);
            m_sen = 1; m_sdy = st;
            m_y = m_y + st;
            m_rem = m_rem - st;
            m_score = imin(m_score + st, 65535);
            if (m_rem == 0) launch();
         end
      end
   endtask

   task automatic compare_all();
      check("state",     int'(state),     m_state);
      check("doodle_y",  int'(doodle_y),  m_y);
      check("speed_y",   int'(speed_y),   m_spd);
      check("fly",       int'(fly),       m_fly);
      check("scroll_en", int'(scroll_en), m_sen);
      check("scroll_dy", int'(scroll_dy), m_sdy);
      check("score",     int'(score),     m_score);
      check("game_over", int'(game_over), m_go);
   endtask

   // One clock: drive inputs, step the model at the edge, compare 1 time unit later.
   task automatic cyc(input bit s, input bit ft, input bit b, input int mv, input bit rn);
      start = s; frame_tick = ft; bump = b; movement = mv[9:0]; rst = rn;
      @(posedge clk);
      model_step(s, ft, b, mv, rn);
      #1;
      compare_all();
   endtask

   task automatic ticks(input int n, input bit b);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, b, 0, 1'b1);
   endtask

   initial begin
      model_reset();

      // Reset values
      cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
      check("rst_y", int'(doodle_y), 425);
      check("rst_state", int'(state), 0);

      // Launch and full rise
      cyc(1'b1, 1'b0, 1'b0, 0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 0, 1'b1);
      check("rise_y1", int'(doodle_y), 405);
      ticks(19, 1'b0);
      check("apex_y", int'(doodle_y), 215);
      check("apex_spd", int'(speed_y), 0);
      check("apex_fly", int'(fly), 0);
      check("apex_state", int'(state), 2);

      // Free fall to game over, bounded
      for (int i = 0; i < 200 && m_state != 4; i++) ticks(1, 1'b0);
      check("over_state", int'(state), 4);
      check("over_flag", int'(game_over), 1);
      ticks(3, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 0, 1'b1);

      // Restart from OVER with a simultaneous tick: no motion applied
      cyc(1'b1, 1'b1, 1'b0, 0, 1'b1);
      check("restart_state", int'(state), 1);
      check("restart_y", int'(doodle_y), 425);
      check("restart_go", int'(game_over), 0);
      check("restart_score", int'(score), 0);

      // Rise with bump held (ignored), fall a little, land with movement 100
      ticks(20, 1'b1);
      ticks(4, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 100, 1'b1);
      check("land_y", int'(doodle_y), 325);
      check("land_state", int'(state), 3);
      for (int i = 0; i < 13; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 55, 1'b1);
         check("scr_en", int'(scroll_en), 1);
         check("scr_dy", int'(scroll_dy), (i < 12) ? 8 : 4);
      end
      check("scr_end_y", int'(doodle_y), 425);
      check("scr_end_score", int'(score), 100);
      check("scr_end_state", int'(state), 1);
      check("scr_end_spd", int'(speed_y), 20);
      check("scr_end_fly", int'(fly), 1);
      cyc(1'b0, 1'b0, 1'b0, 0, 1'b1);
      check("scr_pulse_off", int'(scroll_en), 0);

      // Landing with movement 0 relaunches directly
      ticks(20, 1'b0);
      ticks(2, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 0, 1'b1);
      check("m0_state", int'(state), 1);
      check("m0_y", int'(doodle_y), 425);
      check("m0_spd", int'(speed_y), 20);
      check("m0_sen", int'(scroll_en), 0);

      // Reset in the middle of a scroll
      ticks(20, 1'b0);
      ticks(1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 200, 1'b1);
      ticks(5, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
      check("mid_rst_state", int'(state), 0);
      check("mid_rst_score", int'(score), 0);
      check("mid_rst_sen", int'(scroll_en), 0);
      check("mid_rst_y", int'(doodle_y), 425);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         bit s, ft, b, rn;
         int mv;
         s  = ($urandom_range(0, 15) == 0);
         ft = ($urandom_range(0, 3) != 0);
         b  = ($urandom_range(0, 5) == 0);
         rn = ($urandom_range(0, 499) != 0);
         mv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 1023));
         cyc(s, ft, b, mv, rn);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
